// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants for the 4-point DCT core
// Contents: HEVC 4-point coefficients, default sample widths, pipeline depth.
package dct_pkg;

   localparam int C64 = 64;
   localparam int C83 = 83;
   localparam int C36 = 36;

   localparam int DCT4_IN_W  = 19;
   localparam int DCT4_OUT_W = 28;
   localparam int DCT4_LAT   = 3;

endpackage

// File: rtl/mcm_83_36.sv
// rtl/mcm_83_36.sv - shift-add multiplier producing 83*b and 36*b
// Ports:
//   b   in  IN_W   signed operand
//   p83 out OUT_W  signed 83*b
//   p36 out OUT_W  signed 36*b
module mcm_83_36 #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 28
) (
   input  logic signed [IN_W-1:0]  b,
   output logic signed [OUT_W-1:0] p83,
   output logic signed [OUT_W-1:0] p36
);

   // Widen first so no partial sum can wrap before the result width.
   logic signed [OUT_W-1:0] bx;

   assign bx  = OUT_W'(b);
   // 83 = 64 + 16 + 2 + 1
   assign p83 = (bx <<< 6) + (bx <<< 4) + (bx <<< 1) + bx;
   // 36 = 32 + 4
   assign p36 = (bx <<< 5) + (bx <<< 2);

endmodule

// File: rtl/dct4_core_pipe.sv
// rtl/dct4_core_pipe.sv - 3-stage 4-point forward DCT, one row per clock
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid, i_stall  input row valid, global pipeline freeze
//   i_0..i_3          signed samples x0..x3 (natural order)
//   o_valid           o_0..o_3 carry a result row
//   o_row, o_last     row index within the 4x4 block, high on row 3
//   o_0..o_3          signed y0, y2, y1, y3 (even-first order)
module dct4_core_pipe
   import dct_pkg::*;
#(
   parameter int IN_W  = DCT4_IN_W,
   parameter int OUT_W = DCT4_OUT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_valid,
   input  logic                    i_stall,
   input  logic signed [IN_W-1:0]  i_0,
   input  logic signed [IN_W-1:0]  i_1,
   input  logic signed [IN_W-1:0]  i_2,
   input  logic signed [IN_W-1:0]  i_3,
   output logic                    o_valid,
   output logic [1:0]              o_row,
   output logic                    o_last,
   output logic signed [OUT_W-1:0] o_0,
   output logic signed [OUT_W-1:0] o_1,
   output logic signed [OUT_W-1:0] o_2,
   output logic signed [OUT_W-1:0] o_3
);

   localparam int S1_W = IN_W + 1;

   // stage 1: butterfly
   logic                   v1;
   logic signed [S1_W-1:0] a0_r, a1_r, b0_r, b1_r;
   logic signed [S1_W-1:0] a0_c, a1_c, b0_c, b1_c;

   // stage 2: constant products
   logic                    v2;
   logic signed [OUT_W-1:0] e0_r, e1_r, p0_r, p1_r, p2_r, p3_r;
   logic signed [OUT_W-1:0] e0_c, e1_c;
   logic signed [OUT_W-1:0] b0_83, b0_36, b1_83, b1_36;

   // index the next valid row will take when it reaches the outputs
   logic [1:0] row_cnt;

   assign a0_c = S1_W'(i_0) + S1_W'(i_3);
   assign a1_c = S1_W'(i_1) + S1_W'(i_2);
   assign b0_c = S1_W'(i_0) - S1_W'(i_3);
   assign b1_c = S1_W'(i_1) - S1_W'(i_2);

   // 64* is a plain shift of the sign-extended sum/difference
   assign e0_c = (OUT_W'(a0_r) + OUT_W'(a1_r)) <<< 6;
   assign e1_c = (OUT_W'(a0_r) - OUT_W'(a1_r)) <<< 6;

   mcm_83_36 #(.IN_W(S1_W), .OUT_W(OUT_W)) u_mcm_b0 (
      .b   (b0_r),
      .p83 (b0_83),
      .p36 (b0_36)
   );

   mcm_83_36 #(.IN_W(S1_W), .OUT_W(OUT_W)) u_mcm_b1 (
      .b   (b1_r),
      .p83 (b1_83),
      .p36 (b1_36)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         a0_r    <= '0;
         a1_r    <= '0;
         b0_r    <= '0;
         b1_r    <= '0;
         v2      <= 1'b0;
         e0_r    <= '0;
         e1_r    <= '0;
         p0_r    <= '0;
         p1_r    <= '0;
         p2_r    <= '0;
         p3_r    <= '0;
         row_cnt <= 2'd0;
         o_valid <= 1'b0;
         o_row   <= 2'd0;
         o_last  <= 1'b0;
         o_0     <= '0;
         o_1     <= '0;
         o_2     <= '0;
         o_3     <= '0;
      end else if (!i_stall) begin
         v1   <= i_valid;
         a0_r <= a0_c;
         a1_r <= a1_c;
         b0_r <= b0_c;
         b1_r <= b1_c;

         v2   <= v1;
         e0_r <= e0_c;
         e1_r <= e1_c;
         p0_r <= b0_83;
         p1_r <= b1_36;
         p2_r <= b0_36;
         p3_r <= b1_83;

         o_valid <= v2;
         o_last  <= v2 && (row_cnt == 2'd3);
         // Bubbles leave the result and row index untouched.
         if (v2) begin
            o_0     <= e0_r;
            o_1     <= e1_r;
            o_2     <= p0_r + p1_r;
            o_3     <= p2_r - p3_r;
            o_row   <= row_cnt;
            row_cnt <= row_cnt + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_dct4_core_pipe.sv
// tb/tb_dct4_core_pipe.sv - scoreboard bench for dct4_core_pipe
module tb_dct4_core_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic               i_valid, i_stall;
   logic signed [18:0] i_0, i_1, i_2, i_3;
   logic               o_valid, o_last;
   logic [1:0]         o_row;
   logic signed [27:0] o_0, o_1, o_2, o_3;

   dct4_core_pipe dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .i_stall (i_stall),
      .i_0     (i_0),
      .i_1     (i_1),
      .i_2     (i_2),
      .i_3     (i_3),
      .o_valid (o_valid),
      .o_row   (o_row),
      .o_last  (o_last),
      .o_0     (o_0),
      .o_1     (o_1),
      .o_2     (o_2),
      .o_3     (o_3)
   );

   typedef struct {
      logic signed [27:0] y0, y2, y1, y3;
      logic [1:0]         row;
      logic               last;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [1:0] exp_row;
   logic [1:0] r1_row;
   int         n_chk = 0;
   int         n_fail = 0;

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input int x0, input int x1, input int x2, input int x3,
                       input int y0, input int y2, input int y1, input int y3);
      i_0 = 19'(x0); i_1 = 19'(x1); i_2 = 19'(x2); i_3 = 19'(x3);
      i_valid = 1'b1;
      @(posedge clk);
      sb.push_back('{28'(y0), 28'(y2), 28'(y1), 28'(y3), exp_row, (exp_row == 2'd3)});
      exp_row = exp_row + 2'd1;
      #1;
   endtask

   task automatic idle();
      i_valid = 1'b0;
      i_0 = '0; i_1 = '0; i_2 = '0; i_3 = '0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      check("drain_empty", sb.size(), 0);
      #1;
   endtask

   // monitor: an output row is consumed when it is valid and not stalled
   always @(negedge clk) begin
      if (rst_n && o_valid && !i_stall) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_row: got row %0d y0 %0d, expected no output", o_row, o_0);
         end else begin
            mon_e = sb.pop_front();
            check("y0", o_0, mon_e.y0);
            check("y2", o_1, mon_e.y2);
            check("y1", o_2, mon_e.y1);
            check("y3", o_3, mon_e.y3);
            check("o_row", o_row, mon_e.row);
            check("o_last", o_last, mon_e.last);
         end
      end
   end

   initial begin
      rst_n = 1'b0; i_stall = 1'b0; exp_row = 2'd0; r1_row = 2'd0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_o_valid", o_valid, 0);
      check("rst_o_row", o_row, 0);
      check("rst_o_last", o_last, 0);
      check("rst_o_0", o_0, 0);
      check("rst_o_3", o_3, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single row, exact latency
      send(1, 1, 1, 1, 256, 0, 0, 0);
      idle();
      @(negedge clk); check("lat_cycle1_valid", o_valid, 0);
      @(negedge clk); check("lat_cycle2_valid", o_valid, 0);
      @(negedge clk); check("lat_cycle3_valid", o_valid, 1);
      drain();

      // impulses and extreme (row 3 of first block)
      send(1, 0, 0, 0, 64, 64, 83, 36);
      send(0, 0, 0, -1, -64, -64, 83, 36);
      send(-262144, -262144, -262144, -262144, -67108864, 0, 0, 0);
      idle();
      drain();

      // five back-to-back rows: o_row 0,1,2,3,0
      for (int k = 1; k <= 5; k++) send(k, 0, 0, 0, 64*k, 64*k, 83*k, 36*k);
      idle();
      drain();

      // rows 1,2, bubble, row 3
      send(0, 1, 0, 0, 64, -64, 36, -83);
      send(0, 2, 0, 0, 128, -128, 72, -166);
      idle();
      @(posedge clk); #1;
      send(0, 3, 0, 0, 192, -192, 108, -249);
      idle();
      drain();

      send(262143, 262143, -262144, -262144, -128, 0, 62390153, -24641489);
      idle();
      drain();

      // stall with three rows in flight; a held input row must not be taken
      r1_row = exp_row;
      send(0, 0, 1, 0, 64, -64, -36, 83);
      send(0, 0, 2, 0, 128, -128, -72, 166);
      send(0, 0, 3, 0, 192, -192, -108, 249);
      i_stall = 1'b1;
      i_0 = 19'(0); i_1 = 19'(0); i_2 = 19'(4); i_3 = 19'(0);
      i_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_o_valid", o_valid, 1);
         check("stall_o_row", o_row, r1_row);
         check("stall_o_0", o_0, 64);
         check("stall_o_2", o_2, -36);
      end
      @(posedge clk); #1;
      i_stall = 1'b0;
      send(0, 0, 4, 0, 256, -256, -144, 332);
      idle();
      drain();

      // reset mid-block discards in-flight rows and restarts the row count
      send(1, 2, 3, 4, 640, 0, -285, -25);
      send(1, 2, 3, 4, 640, 0, -285, -25);
      idle();
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb.delete();
      exp_row = 2'd0;
      #1;
      check("midrst_o_valid", o_valid, 0);
      check("midrst_o_row", o_row, 0);
      check("midrst_o_last", o_last, 0);
      check("midrst_o_0", o_0, 0);
      check("midrst_o_2", o_2, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(4, 3, 2, 1, 640, 0, 285, 25);
      idle();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
